// File: rtl/seg_seq_pkg.sv
// seg_seq_pkg: shared state type, sizes and one-hot helper for the digit sequencer.
package seg_seq_pkg;
    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, PAUSE = 2'd2} state_t;
    localparam int MAX_DIGITS = 8;
    localparam int IDX_W = 3;
    function automatic logic [MAX_DIGITS-1:0] idx_to_onehot(input logic [IDX_W-1:0] idx);
        logic [MAX_DIGITS-1:0] r;
        r = '0;
        r[idx] = 1'b1;
        return r;
    endfunction
endpackage

// File: rtl/seg_seq_prescaler.sv
// seg_seq_prescaler: dwell counter; expire is an immediate compare so a lowered dwell takes effect at once.
module seg_seq_prescaler #(
    parameter int DWELL_W = 24
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clr,
    input  logic               en,
    input  logic [DWELL_W-1:0] dwell,
    output logic               expire
);
    logic [DWELL_W-1:0] count;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            count <= '0;
        else if (clr)
            count <= '0;
        else if (en)
            count <= count + 1'b1;
    end
    assign expire = count >= dwell;
endmodule

// File: rtl/seg_digit_sequencer.sv
// seg_digit_sequencer: one-hot digit scan controller with run/pause/step, direction and load.
// Optional SEG_SEQ_BLANK_EN adds a blank input that forces digit_onehot to zero (also zero in IDLE).
module seg_digit_sequencer
    import seg_seq_pkg::*;
#(
    parameter int DIGITS  = 8,
    parameter int DWELL_W = 24
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  ena,
    input  logic                  start,
    input  logic                  stop,
    input  logic                  step,
    input  logic                  dir,
    input  logic                  load_en,
    input  logic [IDX_W-1:0]      load_val,
    input  logic [DWELL_W-1:0]    dwell,
`ifdef SEG_SEQ_BLANK_EN
    input  logic                  blank,
`endif
    output logic [MAX_DIGITS-1:0] digit_onehot,
    output logic [IDX_W-1:0]      digit_idx,
    output logic                  running,
    output logic                  tick
);
    localparam logic [IDX_W:0]   DIG  = (IDX_W+1)'(DIGITS);
    localparam logic [IDX_W-1:0] LAST = IDX_W'(DIGITS - 1);
`ifdef SEG_SEQ_BLANK_EN
    localparam logic [MAX_DIGITS-1:0] RST_ONEHOT = '0;
`else
    localparam logic [MAX_DIGITS-1:0] RST_ONEHOT = MAX_DIGITS'(1);
`endif

    state_t                state, state_n;
    logic                  adv, cnt_clr, cnt_en, expire, step_ok;
    logic [IDX_W-1:0]      idx_n, load_idx, idx_inc, idx_dec;
    logic [MAX_DIGITS-1:0] onehot_n;

    seg_seq_prescaler #(.DWELL_W(DWELL_W)) u_pre (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (cnt_clr),
        .en     (cnt_en),
        .dwell  (dwell),
        .expire (expire)
    );

    // a load in the same cycle swallows any advance but lets stop/start still move the state
    assign step_ok = step & ~load_en;

    always_comb begin
        state_n = state;
        adv     = 1'b0;
        cnt_clr = 1'b0;
        cnt_en  = 1'b0;
        if (ena) begin
            case (state)
                RUN: begin
                    if (stop) state_n = PAUSE;
                    else if (expire) begin
                        adv     = 1'b1;
                        cnt_clr = 1'b1;
                    end else cnt_en = 1'b1;
                end
                IDLE, PAUSE: begin
                    if (stop) state_n = state;
                    else if (start) begin
                        state_n = RUN;
                        cnt_clr = 1'b1;
                    end else if (step_ok) begin
                        state_n = PAUSE;
                        adv     = 1'b1;
                    end
                end
                default: state_n = IDLE;
            endcase
            if (load_en) begin
                adv     = 1'b0;
                cnt_en  = 1'b0;
                cnt_clr = 1'b1;
            end
        end
    end

    assign load_idx = ({1'b0, load_val} >= DIG) ? LAST : load_val;
    assign idx_inc  = (digit_idx == LAST) ? '0 : digit_idx + 1'b1;
    assign idx_dec  = (digit_idx == '0) ? LAST : digit_idx - 1'b1;
    assign idx_n    = load_en ? load_idx : adv ? (dir ? idx_dec : idx_inc) : digit_idx;
`ifdef SEG_SEQ_BLANK_EN
    assign onehot_n = (blank || state_n == IDLE) ? '0 : idx_to_onehot(idx_n);
`else
    assign onehot_n = idx_to_onehot(idx_n);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            digit_idx    <= '0;
            digit_onehot <= RST_ONEHOT;
            running      <= 1'b0;
            tick         <= 1'b0;
        end else if (!ena) begin
            tick <= 1'b0;
        end else begin
            state        <= state_n;
            digit_idx    <= idx_n;
            digit_onehot <= onehot_n;
            running      <= state_n == RUN;
            tick         <= adv;
        end
    end
endmodule

// File: tb/tb_seg_digit_sequencer.sv
// tb_seg_digit_sequencer: vector table, corner sequences and random run against a spec-level model (DIGITS=8 and 5).
module tb_seg_digit_sequencer;
    logic        clk = 0, rst_n = 0, ena = 0, start = 0, stop = 0, step = 0, dir = 0, load_en = 0, blank = 0;
    logic [2:0]  load_val = 0;
    logic [23:0] dwell = 0;
    logic [7:0]  oh8, oh5;
    logic [2:0]  idx8, idx5;
    logic        run8, run5, tk8, tk5;
    int          errors = 0, checks = 0;

    always #5 clk = ~clk;

    seg_digit_sequencer #(.DIGITS(8), .DWELL_W(24)) dut8 (
        .clk(clk), .rst_n(rst_n), .ena(ena), .start(start), .stop(stop), .step(step), .dir(dir),
        .load_en(load_en), .load_val(load_val), .dwell(dwell),
`ifdef SEG_SEQ_BLANK_EN
        .blank(blank),
`endif
        .digit_onehot(oh8), .digit_idx(idx8), .running(run8), .tick(tk8));

    seg_digit_sequencer #(.DIGITS(5), .DWELL_W(24)) dut5 (
        .clk(clk), .rst_n(rst_n), .ena(ena), .start(start), .stop(stop), .step(step), .dir(dir),
        .load_en(load_en), .load_val(load_val), .dwell(dwell),
`ifdef SEG_SEQ_BLANK_EN
        .blank(blank),
`endif
        .digit_onehot(oh5), .digit_idx(idx5), .running(run5), .tick(tk5));

`ifdef SEG_SEQ_BLANK_EN
    localparam logic [7:0] RST_OH = 8'h00;
`else
    localparam logic [7:0] RST_OH = 8'h01;
`endif

    // spec-level model: digit count, mode flags and an integer dwell count per DUT
    int         md[2] = '{8, 5};
    bit         m_run[2], m_pause[2], m_tick[2];
    int         m_cnt[2], m_idx[2];
    logic [7:0] m_oh[2];

    function automatic void model_reset();
        for (int d = 0; d < 2; d++) begin
            m_run[d] = 0; m_pause[d] = 0; m_tick[d] = 0; m_cnt[d] = 0; m_idx[d] = 0; m_oh[d] = RST_OH;
        end
    endfunction

    function automatic void model_clock();
        for (int d = 0; d < 2; d++) begin
            bit adv;
            adv = 0;
            if (!ena) begin
                m_tick[d] = 0;
                continue;
            end
            if (m_run[d]) begin
                if (stop) begin m_run[d] = 0; m_pause[d] = 1; end
                else if (m_cnt[d] >= int'(dwell)) begin adv = 1; m_cnt[d] = 0; end
                else m_cnt[d]++;
            end else if (!stop) begin
                if (start) begin m_run[d] = 1; m_pause[d] = 0; m_cnt[d] = 0; end
                else if (step && !load_en) begin adv = 1; m_pause[d] = 1; end
            end
            if (load_en) begin
                adv = 0;
                m_cnt[d] = 0;
                m_idx[d] = (int'(load_val) < md[d]) ? int'(load_val) : md[d] - 1;
            end
            if (adv) m_idx[d] = dir ? (m_idx[d] + md[d] - 1) % md[d] : (m_idx[d] + 1) % md[d];
            m_tick[d] = adv;
            m_oh[d] = 8'(1 << m_idx[d]);
`ifdef SEG_SEQ_BLANK_EN
            if (blank || (!m_run[d] && !m_pause[d])) m_oh[d] = 8'h00;
`endif
        end
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare_all();
        chk("idx8", 32'(idx8), 32'(m_idx[0]));
        chk("onehot8", 32'(oh8), 32'(m_oh[0]));
        chk("running8", 32'(run8), 32'(m_run[0]));
        chk("tick8", 32'(tk8), 32'(m_tick[0]));
        chk("idx5", 32'(idx5), 32'(m_idx[1]));
        chk("onehot5", 32'(oh5), 32'(m_oh[1]));
        chk("running5", 32'(run5), 32'(m_run[1]));
        chk("tick5", 32'(tk5), 32'(m_tick[1]));
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_idx8"}, 32'(idx8), 0);
        chk({tag, "_oh8"}, 32'(oh8), 32'(RST_OH));
        chk({tag, "_run8"}, 32'(run8), 0);
        chk({tag, "_tick8"}, 32'(tk8), 0);
        chk({tag, "_idx5"}, 32'(idx5), 0);
        chk({tag, "_oh5"}, 32'(oh5), 32'(RST_OH));
    endtask

    task automatic cycle();
        @(posedge clk);
        model_clock();
        #1;
        compare_all();
    endtask

    task automatic set_in(input bit st, input bit sp, input bit se, input bit di, input bit ld,
                          input int lv, input int dw);
        start = st; stop = sp; step = se; dir = di; load_en = ld;
        load_val = 3'(lv); dwell = 24'(dw);
    endtask

    typedef struct {
        bit st, sp, se, di, ld, en;
        int lv, dw, e_idx;
        bit e_tick, e_run;
    } vec_t;

    function automatic vec_t v(bit st, bit sp, bit se, bit di, bit ld, bit en, int lv, int dw,
                               int ei, bit et, bit er);
        vec_t r;
        r.st = st; r.sp = sp; r.se = se; r.di = di; r.ld = ld; r.en = en;
        r.lv = lv; r.dw = dw; r.e_idx = ei; r.e_tick = et; r.e_run = er;
        return r;
    endfunction

    vec_t tbl[20];
    int   ticks, held;

    initial begin
        tbl[0]  = v(1,0,0,0,0,1, 0,3, 0,0,1);
        tbl[1]  = v(1,0,0,0,0,1, 0,3, 0,0,1);
        tbl[2]  = v(1,0,0,0,0,1, 0,3, 0,0,1);
        tbl[3]  = v(1,0,0,0,0,1, 0,3, 0,0,1);
        tbl[4]  = v(1,0,0,0,0,1, 0,3, 1,1,1);
        tbl[5]  = v(1,1,0,0,0,1, 0,3, 1,0,0);
        tbl[6]  = v(0,0,1,0,0,1, 0,3, 2,1,0);
        tbl[7]  = v(0,0,1,1,0,1, 0,3, 1,1,0);
        tbl[8]  = v(0,1,0,0,1,1, 6,3, 6,0,0);
        tbl[9]  = v(0,0,1,0,1,1, 7,3, 7,0,0);
        tbl[10] = v(0,0,1,0,0,1, 0,3, 0,1,0);
        tbl[11] = v(0,0,1,1,0,1, 0,3, 7,1,0);
        tbl[12] = v(1,0,0,1,0,1, 0,0, 7,0,1);
        tbl[13] = v(1,0,0,1,0,1, 0,0, 6,1,1);
        tbl[14] = v(1,0,0,1,0,1, 0,0, 5,1,1);
        tbl[15] = v(0,0,1,0,0,1, 0,0, 6,1,1);
        tbl[16] = v(0,0,0,0,0,0, 0,0, 6,0,1);
        tbl[17] = v(0,0,1,0,0,0, 0,0, 6,0,1);
        tbl[18] = v(0,0,0,0,0,1, 0,0, 7,1,1);
        tbl[19] = v(0,1,0,0,0,1, 0,0, 7,0,0);

        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_reset_vals("reset");
        rst_n = 1;
        ena = 1;

        for (int i = 0; i < 20; i++) begin
            set_in(tbl[i].st, tbl[i].sp, tbl[i].se, tbl[i].di, tbl[i].ld, tbl[i].lv, tbl[i].dw);
            ena = tbl[i].en;
            cycle();
            chk($sformatf("tbl%0d_idx", i), 32'(idx8), 32'(tbl[i].e_idx));
            chk($sformatf("tbl%0d_tick", i), 32'(tk8), 32'(tbl[i].e_tick));
            chk($sformatf("tbl%0d_run", i), 32'(run8), 32'(tbl[i].e_run));
        end
        ena = 1;

        // clamp on the 5-digit instance
        set_in(0, 0, 0, 0, 1, 7, 0);
        cycle();
        chk("clamp5_idx", 32'(idx5), 4);
        chk("clamp8_idx", 32'(idx8), 7);

        // full wrap at dwell=3: 8 advances in 32 cycles, back to digit 0
        set_in(1, 0, 0, 0, 1, 0, 3);
        cycle();
        set_in(1, 0, 0, 0, 0, 0, 3);
        ticks = 0;
        for (int i = 0; i < 32; i++) begin
            cycle();
            ticks += int'(tk8);
        end
        chk("wrap_ticks", 32'(ticks), 8);
        chk("wrap_idx", 32'(idx8), 0);
        chk("wrap_tick_last", 32'(tk8), 1);

        // pause at 5 then three single steps
        set_in(0, 1, 0, 0, 0, 0, 3);
        cycle();
        set_in(0, 0, 0, 0, 1, 5, 3);
        cycle();
        for (int i = 0; i < 3; i++) begin
            set_in(0, 0, 1, 0, 0, 0, 3);
            cycle();
            chk($sformatf("step%0d_idx", i), 32'(idx8), 32'((6 + i) % 8));
            set_in(0, 0, 0, 0, 0, 0, 3);
            cycle();
        end

        // dwell lowered below the running count advances on the next edge
        set_in(1, 0, 0, 0, 1, 0, 10);
        cycle();
        set_in(1, 0, 0, 0, 0, 0, 10);
        repeat (7) cycle();
        chk("dwchg_pre_idx", 32'(idx8), 0);
        dwell = 24'd2;
        cycle();
        chk("dwchg_idx", 32'(idx8), 1);
        chk("dwchg_tick", 32'(tk8), 1);

        // ena low freezes everything
        repeat (2) cycle();
        ena = 0;
        held = int'(idx8);
        for (int i = 0; i < 20; i++) begin
            step = i[0];
            cycle();
            chk("freeze_idx", 32'(idx8), 32'(held));
            chk("freeze_tick", 32'(tk8), 0);
        end
        ena = 1;
        step = 0;
        repeat (6) cycle();

        // asynchronous reset between edges
        #3 rst_n = 0;
        #1;
        model_reset();
        check_reset_vals("async");
        @(posedge clk);
        #1;
        check_reset_vals("async_hold");
        rst_n = 1;

`ifdef SEG_SEQ_BLANK_EN
        set_in(1, 0, 0, 0, 0, 0, 0);
        blank = 1;
        cycle();
        for (int i = 0; i < 4; i++) begin
            cycle();
            chk("blank_oh", 32'(oh8), 0);
        end
        chk("blank_idx", 32'(idx8), 4);
        blank = 0;
        cycle();
`endif

        for (int i = 0; i < 600; i++) begin
            start    = ($urandom_range(0, 3) == 0);
            stop     = ($urandom_range(0, 15) == 0);
            step     = ($urandom_range(0, 3) == 0);
            dir      = 1'($urandom_range(0, 1));
            load_en  = ($urandom_range(0, 19) == 0);
            load_val = 3'($urandom_range(0, 7));
            ena      = ($urandom_range(0, 9) != 0);
            blank    = ($urandom_range(0, 5) == 0);
            if ($urandom_range(0, 7) == 0) dwell = 24'($urandom_range(0, 4));
            cycle();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
